// File: rtl/bpsk_corr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bpsk_corr_pkg
//  Purpose  : Shared definitions for the BPSK preamble correlator: default
//             preamble/carrier constants (also used by the modulator), the
//             correlator state encoding and the preamble expansion function.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package bpsk_corr_pkg;

    // Defaults shared with the modulator
    localparam int                         C_PREAMBLE_BITS = 8;
    localparam int                         C_WAVELENGTH    = 4;
    localparam logic [C_PREAMBLE_BITS-1:0] C_PREAMBLE      = 8'b1011_0010;

    // Upper bounds for the expansion function's fixed-width interface
    localparam int C_MAX_BITS = 64;
    localparam int C_MAX_REF  = 1024;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SEARCH = 2'd1,
        PEAK   = 2'd2,
        LOCKED = 2'd3
    } corr_state_t;

    // Expands nbits preamble symbols into nbits*wl reference samples,
    // LSB-aligned. Symbol bits[nbits-1] is transmitted first and its first
    // sample lands at the MSB of the reference. A '1' symbol is low for the
    // first half of the carrier period and high for the second; a '0' is the
    // complement. With odd wl the second half gets the extra sample.
    function automatic logic [C_MAX_REF-1:0] expand_preamble(
        input logic [C_MAX_BITS-1:0] bits,
        input int                    nbits,
        input int                    wl
    );
        logic [C_MAX_REF-1:0] exp_bits;
        int                   pos;
        logic                 second_half;
        exp_bits = '0;
        pos      = nbits * wl - 1;
        for (int i = nbits - 1; i >= 0; i--) begin
            for (int s = 0; s < wl; s++) begin
                second_half   = (s >= wl / 2);
                exp_bits[pos] = bits[i] ? second_half : ~second_half;
                pos           = pos - 1;
            end
        end
        return exp_bits;
    endfunction

endpackage : bpsk_corr_pkg
`default_nettype wire

// File: rtl/preamble_correlator_sync_popcount_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : popcount_pipe
//  Purpose  : Registered binary adder tree counting the ones in an N-bit word.
//             Fixed latency of $clog2(N) cycles regardless of in_valid; a
//             valid bit and a side-band tag travel alongside the data.
//  Ports    : clk       - clock, rising edge
//             rst       - synchronous active-high reset (clears valid tags)
//             in_valid  - qualifies in_bits / in_tag
//             in_bits   - word to count
//             in_tag    - side-band data delayed with the count
//             out_valid - in_valid delayed by the tree latency
//             out_tag   - in_tag delayed by the tree latency
//             out_count - number of ones in the matching in_bits
//  Revision : 1.0 - initial release
// ============================================================================
module popcount_pipe #(
    parameter int N     = 32,
    parameter int TAG_W = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [N-1:0]           in_bits,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    output logic [TAG_W-1:0]       out_tag,
    output logic [$clog2(N+1)-1:0] out_count
);

    localparam int LAT = $clog2(N);
    localparam int CW  = $clog2(N + 1);
    localparam int P   = 1 << LAT;

    // Input padded to a power of two so every tree level halves cleanly
    logic [P-1:0]  w_padded;
    logic [CW-1:0] w_leaf [0:P-1];

    assign w_padded = P'(in_bits);

    always_comb begin
        for (int j = 0; j < P; j++) begin
            w_leaf[j] = CW'(w_padded[j]);
        end
    end

    // Level l holds P>>l partial sums, each registered once
    for (genvar l = 1; l <= LAT; l++) begin : g_lvl
        logic [CW-1:0] r_sum [0:(P>>l)-1];
        if (l == 1) begin : g_first
            always_ff @(posedge clk) begin
                for (int j = 0; j < (P >> l); j++) begin
                    r_sum[j] <= w_leaf[2*j] + w_leaf[2*j+1];
                end
            end
        end else begin : g_upper
            always_ff @(posedge clk) begin
                for (int j = 0; j < (P >> l); j++) begin
                    r_sum[j] <= g_lvl[l-1].r_sum[2*j] + g_lvl[l-1].r_sum[2*j+1];
                end
            end
        end
    end

    assign out_count = g_lvl[LAT].r_sum[0];

    // Valid tags are the only state cleared by reset: beats already in the
    // tree are discarded simply by dropping their valid bit.
    logic [LAT-1:0]   r_vpipe;
    logic [TAG_W-1:0] r_tpipe [0:LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vpipe <= '0;
        end else begin
            r_vpipe[0] <= in_valid;
            for (int k = 1; k < LAT; k++) begin
                r_vpipe[k] <= r_vpipe[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_tpipe[0] <= in_tag;
        for (int k = 1; k < LAT; k++) begin
            r_tpipe[k] <= r_tpipe[k-1];
        end
    end

    assign out_valid = r_vpipe[LAT-1];
    assign out_tag   = r_tpipe[LAT-1];

endmodule : popcount_pipe
`default_nettype wire

// File: rtl/preamble_correlator_sync.sv
`default_nettype none
// ============================================================================
//  Module   : preamble_correlator_sync
//  Purpose  : Sliding-window correlator for the expanded BPSK preamble.
//             Accepts the preamble in either polarity, refines timing to the
//             best-matching window end within one carrier period, then holds
//             lock until re-armed.
//  Ports    : clk          - clock, rising edge
//             clr          - synchronous active-high reset
//             sample_valid - qualifies sample; all sample-side state stalls
//             sample       - hard-sliced sample
//             rearm        - pulse; returns LOCKED to SEARCH
//             detect       - one-cycle pulse on lock
//             locked       - high while locked
//             inverted     - lock was on the inverted preamble
//             offset       - phase index of the best window end
//             score        - effective mismatch count at the best point
//  Revision : 1.0 - initial release
// ============================================================================
module preamble_correlator_sync
    import bpsk_corr_pkg::*;
#(
    parameter int                       PREAMBLE_BITS = C_PREAMBLE_BITS,
    parameter int                       WAVELENGTH    = C_WAVELENGTH,
    parameter logic [PREAMBLE_BITS-1:0] PREAMBLE      = C_PREAMBLE,
    parameter int                       THRESHOLD     = 2
) (
    input  logic                                          clk,
    input  logic                                          clr,
    input  logic                                          sample_valid,
    input  logic                                          sample,
    input  logic                                          rearm,
    output logic                                          detect,
    output logic                                          locked,
    output logic                                          inverted,
    // WAVELENGTH >= 2 is enforced below, so this width is never zero
    output logic [$clog2(WAVELENGTH)-1:0]                 offset,
    output logic [$clog2(PREAMBLE_BITS*WAVELENGTH+1)-1:0] score
);

    localparam int N      = PREAMBLE_BITS * WAVELENGTH;
    localparam int OFF_W  = $clog2(WAVELENGTH);
    localparam int CW     = $clog2(N + 1);
    localparam int FILL_W = $clog2(N);

    localparam logic [C_MAX_REF-1:0] REF_FULL =
        expand_preamble(C_MAX_BITS'(PREAMBLE), PREAMBLE_BITS, WAVELENGTH);
    localparam logic [N-1:0] REF = REF_FULL[N-1:0];

    if (WAVELENGTH < 2) begin : g_chk_wavelength
        $error("WAVELENGTH must be at least 2");
    end
    if (THRESHOLD >= N / 2) begin : g_chk_threshold
        $error("THRESHOLD must be below half the window length");
    end
    if (PREAMBLE_BITS > C_MAX_BITS || N > C_MAX_REF) begin : g_chk_size
        $error("preamble exceeds expansion function limits");
    end

    // ------------------------------------------------------------------
    // Sample side: window, fill count, phase counter
    // ------------------------------------------------------------------
    logic [N-1:0]      r_window;
    logic [FILL_W-1:0] r_fill;
    logic [OFF_W-1:0]  r_phase;
    logic [N-1:0]      w_window_next;
    logic              w_full;

    assign w_window_next = {r_window[N-2:0], sample};
    // r_fill saturates at N-1: the sample arriving then completes a window
    assign w_full        = (r_fill == FILL_W'(N - 1));

    always_ff @(posedge clk) begin
        if (clr) begin
            r_window <= '0;
            r_fill   <= '0;
            r_phase  <= '0;
        end else if (sample_valid) begin
            r_window <= w_window_next;
            if (!w_full) begin
                r_fill <= r_fill + 1'b1;
            end
            if (r_phase == OFF_W'(WAVELENGTH - 1)) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Mismatch count pipeline; tag = {window full, phase of this sample}
    // ------------------------------------------------------------------
    logic             w_pipe_valid;
    logic [OFF_W:0]   w_pipe_tag;
    logic [CW-1:0]    w_pipe_count;

    popcount_pipe #(
        .N     (N),
        .TAG_W (OFF_W + 1)
    ) u_popcount (
        .clk       (clk),
        .rst       (clr),
        .in_valid  (sample_valid),
        .in_bits   (w_window_next ^ REF),
        .in_tag    ({w_full, r_phase}),
        .out_valid (w_pipe_valid),
        .out_tag   (w_pipe_tag),
        .out_count (w_pipe_count)
    );

    // Effective error folds in the inverted preamble: N-m mismatches
    // against ~REF. A strict compare keeps the upright polarity on a tie.
    logic [CW-1:0]    w_m_comp;
    logic             w_inv;
    logic [CW-1:0]    w_e;
    logic             w_beat;
    logic [OFF_W-1:0] w_beat_phase;

    assign w_m_comp     = CW'(N) - w_pipe_count;
    assign w_inv        = (w_m_comp < w_pipe_count);
    assign w_e          = w_inv ? w_m_comp : w_pipe_count;
    // Beats from partially filled windows never reach the FSM
    assign w_beat       = w_pipe_valid && w_pipe_tag[OFF_W];
    assign w_beat_phase = w_pipe_tag[OFF_W-1:0];

    // ------------------------------------------------------------------
    // Lock FSM
    // ------------------------------------------------------------------
    corr_state_t      r_state, w_state_next;
    logic [OFF_W-1:0] r_cd, w_cd_next;
    logic [CW-1:0]    r_best_e, w_best_e_next;
    logic [OFF_W-1:0] r_best_phase, w_best_phase_next;
    logic             r_best_inv, w_best_inv_next;
    logic             r_detect, w_detect_next;
    logic [OFF_W-1:0] r_offset, w_offset_next;
    logic [CW-1:0]    r_score, w_score_next;
    logic             r_inverted, w_inverted_next;

    always_comb begin
        w_state_next      = r_state;
        w_cd_next         = r_cd;
        w_best_e_next     = r_best_e;
        w_best_phase_next = r_best_phase;
        w_best_inv_next   = r_best_inv;
        w_detect_next     = 1'b0;
        w_offset_next     = r_offset;
        w_score_next      = r_score;
        w_inverted_next   = r_inverted;

        case (r_state)
            FILL, SEARCH: begin
                // The first full-window beat is evaluated straight from FILL
                if (w_beat) begin
                    if (w_e <= CW'(THRESHOLD)) begin
                        w_best_e_next     = w_e;
                        w_best_phase_next = w_beat_phase;
                        w_best_inv_next   = w_inv;
                        w_cd_next         = OFF_W'(WAVELENGTH - 1);
                        w_state_next      = PEAK;
                    end else begin
                        w_state_next = SEARCH;
                    end
                end
            end
            PEAK: begin
                if (w_beat) begin
                    if (w_e < r_best_e) begin
                        w_best_e_next     = w_e;
                        w_best_phase_next = w_beat_phase;
                        w_best_inv_next   = w_inv;
                    end
                    w_cd_next = r_cd - 1'b1;
                    if (r_cd == OFF_W'(1)) begin
                        // Outputs take the best point including this beat
                        w_state_next    = LOCKED;
                        w_detect_next   = 1'b1;
                        w_offset_next   = w_best_phase_next;
                        w_score_next    = w_best_e_next;
                        w_inverted_next = w_best_inv_next;
                    end
                end
            end
            LOCKED: begin
                if (rearm) begin
                    w_state_next = SEARCH;
                end
            end
            default: begin
                w_state_next = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state      <= FILL;
            r_cd         <= '0;
            r_best_e     <= '0;
            r_best_phase <= '0;
            r_best_inv   <= 1'b0;
            r_detect     <= 1'b0;
            r_offset     <= '0;
            r_score      <= '0;
            r_inverted   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cd         <= w_cd_next;
            r_best_e     <= w_best_e_next;
            r_best_phase <= w_best_phase_next;
            r_best_inv   <= w_best_inv_next;
            r_detect     <= w_detect_next;
            r_offset     <= w_offset_next;
            r_score      <= w_score_next;
            r_inverted   <= w_inverted_next;
        end
    end

    assign detect   = r_detect;
    assign locked   = (r_state == LOCKED);
    assign inverted = r_inverted;
    assign offset   = r_offset;
    assign score    = r_score;

endmodule : preamble_correlator_sync
`default_nettype wire

// File: tb/tb_preamble_correlator_sync.sv
`default_nettype none
// ============================================================================
//  Module   : tb_preamble_correlator_sync
//  Purpose  : Directed self-checking bench for preamble_correlator_sync with
//             the default 8-symbol / 4-sample preamble.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_preamble_correlator_sync;

    localparam int          WL       = 4;
    localparam int          POP_LAT  = 5;
    // 1011_0010 expanded by hand: 1->0011, 0->1100, first sample at MSB
    localparam logic [31:0] REF_WORD  = 32'h3C33_CC3C;
    localparam logic [31:0] RAND_WORD = 32'hA5F0_1C69;
    // Flipped sample positions (transmit order 0, 10, 20)
    localparam logic [31:0] FLIP2     = 32'h8020_0000;
    localparam logic [31:0] FLIP3     = 32'h8020_0800;

    logic       clk = 1'b0;
    logic       clr;
    logic       sample_valid;
    logic       sample;
    logic       rearm;
    logic       detect;
    logic       locked;
    logic       inverted;
    logic [1:0] offset;
    logic [5:0] score;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int det_count = 0;
    int det_cyc   = 0;
    int idx       = 0;
    int last_cyc  = 0;
    int last_ph   = 0;
    int t_last    = 0;
    int t_phase   = 0;
    int d0        = 0;

    preamble_correlator_sync dut (
        .clk          (clk),
        .clr          (clr),
        .sample_valid (sample_valid),
        .sample       (sample),
        .rearm        (rearm),
        .detect       (detect),
        .locked       (locked),
        .inverted     (inverted),
        .offset       (offset),
        .score        (score)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (detect) begin
            det_count++;
            det_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic s);
        @(negedge clk);
        clr          = 1'b0;
        rearm        = 1'b0;
        sample_valid = v;
        sample       = s;
        if (v) begin
            last_ph  = idx % WL;
            last_cyc = cyc;
            idx++;
        end
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr          = 1'b1;
        rearm        = 1'b0;
        sample_valid = 1'b0;
        sample       = 1'b0;
        idx          = 0;
        step(1'b0, 1'b0);
    endtask

    task automatic pulse_rearm();
        @(negedge clk);
        rearm        = 1'b1;
        sample_valid = 1'b0;
        step(1'b0, 1'b0);
    endtask

    // Sends the top nbits of word, MSB first; gap inserts an idle cycle
    // after every sample.
    task automatic send_word(input logic [31:0] word, input int nbits, input bit gap);
        for (int i = 31; i > 31 - nbits; i--) begin
            step(1'b1, word[i]);
            if (gap) step(1'b0, 1'b0);
        end
        t_last  = last_cyc;
        t_phase = last_ph;
    endtask

    task automatic idle(input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0);
            if (gap) step(1'b0, 1'b0);
        end
    endtask

    initial begin
        clr          = 1'b1;
        sample_valid = 1'b0;
        sample       = 1'b0;
        rearm        = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_detect",   detect,   0);
        check("rst_locked",   locked,   0);
        check("rst_inverted", inverted, 0);
        check("rst_offset",   offset,   0);
        check("rst_score",    score,    0);

        // Random prefix then exact preamble
        do_clr();
        send_word(RAND_WORD, 32, 1'b0);
        d0 = det_count;
        send_word(REF_WORD, 32, 1'b0);
        idle(16, 1'b0);
        check("s1_detect_count", det_count, d0 + 1);
        check("s1_latency",      det_cyc - t_last, POP_LAT + WL);
        check("s1_locked",       locked,   1);
        check("s1_inverted",     inverted, 0);
        check("s1_score",        score,    0);
        check("s1_offset",       offset,   t_phase);
        check("s1_offset_const", offset,   3);

        // Hold in LOCKED, then re-arm and resend
        idle(20, 1'b0);
        check("hold_locked",   locked,    1);
        check("hold_offset",   offset,    3);
        check("hold_score",    score,     0);
        check("hold_inverted", inverted,  0);
        check("hold_no_det",   det_count, d0 + 1);
        pulse_rearm();
        check("rearm_unlock",  locked,    0);
        idle(8, 1'b0);
        d0 = det_count;
        send_word(REF_WORD, 32, 1'b0);
        idle(16, 1'b0);
        check("rearm_detect",  det_count, d0 + 1);
        check("rearm_latency", det_cyc - t_last, POP_LAT + WL);
        check("rearm_offset",  offset,    t_phase);
        check("rearm_locked",  locked,    1);

        // Inverted preamble straight after clr; rearm in FILL is ignored
        do_clr();
        pulse_rearm();
        check("fill_rearm_locked", locked, 0);
        d0 = det_count;
        send_word(~REF_WORD, 32, 1'b0);
        idle(16, 1'b0);
        check("inv_detect",   det_count, d0 + 1);
        check("inv_latency",  det_cyc - t_last, POP_LAT + WL);
        check("inv_inverted", inverted,  1);
        check("inv_score",    score,     0);
        check("inv_offset",   offset,    3);

        // Two flipped samples: still locks with score 2
        do_clr();
        d0 = det_count;
        send_word(REF_WORD ^ FLIP2, 32, 1'b0);
        idle(16, 1'b0);
        check("flip2_detect",   det_count, d0 + 1);
        check("flip2_score",    score,     2);
        check("flip2_inverted", inverted,  0);
        check("flip2_locked",   locked,    1);

        // clr while LOCKED clears outputs; three flips never lock
        do_clr();
        check("clr_locked_lk",  locked,   0);
        check("clr_locked_sc",  score,    0);
        check("clr_locked_off", offset,   0);
        d0 = det_count;
        send_word(REF_WORD ^ FLIP3, 32, 1'b0);
        idle(200, 1'b0);
        check("flip3_no_detect", det_count, d0);
        check("flip3_locked",    locked,    0);

        // Preamble with alternating sample_valid
        do_clr();
        d0 = det_count;
        send_word(REF_WORD, 32, 1'b1);
        idle(16, 1'b1);
        check("gap_detect",  det_count, d0 + 1);
        check("gap_latency", det_cyc - t_last, POP_LAT + WL + 3);
        check("gap_offset",  offset,    3);
        check("gap_score",   score,     0);
        check("gap_inv",     inverted,  0);

        // clr two cycles after the first qualifying beat, inside PEAK
        do_clr();
        d0 = det_count;
        send_word(REF_WORD, 32, 1'b0);
        idle(POP_LAT + 1, 1'b0);
        do_clr();
        check("peak_clr_locked", locked,   0);
        check("peak_clr_score",  score,    0);
        check("peak_clr_inv",    inverted, 0);
        // 31 fresh samples leave the window equal to the reference, but it
        // is still only partially filled
        send_word(REF_WORD << 1, 31, 1'b0);
        idle(40, 1'b0);
        check("peak_clr_no_det", det_count, d0);
        send_word(REF_WORD, 32, 1'b0);
        idle(16, 1'b0);
        check("refill_detect", det_count, d0 + 1);
        check("refill_score",  score,     0);
        check("refill_offset", offset,    t_phase);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_preamble_correlator_sync
`default_nettype wire
